// File: rtl/rect_renderer.sv
`timescale 1ns / 1ps
// Rectangle rasterizer driving the 1-bit frame buffer write port.
// Clears the back buffer on each swap, then fills rectangles from a valid/ready command stream.
module rect_renderer #(
    parameter int unsigned HOR_ACTIVE_PIXELS = 640,
    parameter int unsigned VER_ACTIVE_PIXELS = 480,
    parameter logic        CLEAR_VALUE       = 1'b0,
    parameter int unsigned X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS),
    parameter int unsigned Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS),
    parameter int unsigned ADDR_WIDTH        = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
    input  logic                  clk_rgb,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  swap,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [X_WIDTH:0]      cmd_x0,
    input  logic [Y_WIDTH:0]      cmd_y0,
    input  logic [X_WIDTH:0]      cmd_x1,
    input  logic [Y_WIDTH:0]      cmd_y1,
    input  logic                  cmd_color,
    input  logic                  cmd_last,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam int unsigned XW = X_WIDTH + 1;
    localparam int unsigned YW = Y_WIDTH + 1;

    localparam logic [ADDR_WIDTH-1:0] LastAddr =
        ADDR_WIDTH'(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS - 1);
    localparam logic [ADDR_WIDTH-1:0] RowStep = ADDR_WIDTH'(HOR_ACTIVE_PIXELS);
    localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
    localparam logic [XW-1:0]         XLimit  = XW'(HOR_ACTIVE_PIXELS);
    localparam logic [YW-1:0]         YLimit  = YW'(VER_ACTIVE_PIXELS);
    localparam logic [XW-1:0]         XOne    = XW'(1);
    localparam logic [YW-1:0]         YOne    = YW'(1);
    localparam logic [31:0]           HorBits = 32'(HOR_ACTIVE_PIXELS);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StWaitCmd,
        StDraw,
        StDone
    } state_e;

    // Start-of-rectangle row base as a shift-add over the constant width's set bits.
    function automatic logic [ADDR_WIDTH-1:0] row_base_of(input logic [YW-1:0] y);
        logic [ADDR_WIDTH-1:0] acc;
        acc = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            if (HorBits[i]) acc = acc + (ADDR_WIDTH'(y) << i);
        end
        return acc;
    endfunction

    state_e                state_q, state_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  wr_data_q, wr_data_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  overrun_q, overrun_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [XW-1:0]         x0_q, x0_d;
    logic [XW-1:0]         x1_q, x1_d;
    logic [YW-1:0]         y1_q, y1_d;
    logic                  last_q, last_d;

    logic [XW-1:0]         x1_clip;
    logic [YW-1:0]         y1_clip;
    logic                  cmd_empty;
    logic                  accept;
    logic                  last_col;
    logic                  last_row;
    logic [ADDR_WIDTH-1:0] row_base_new;

    always_comb begin
        x1_clip      = (cmd_x1 > XLimit) ? XLimit : cmd_x1;
        y1_clip      = (cmd_y1 > YLimit) ? YLimit : cmd_y1;
        cmd_empty    = (cmd_x0 >= x1_clip) || (cmd_y0 >= y1_clip);
        accept       = ce && cmd_valid && cmd_ready_q && (state_q == StWaitCmd);
        last_col     = (x_q + XOne) == x1_q;
        last_row     = (y_q + YOne) == y1_q;
        row_base_new = row_base_of(cmd_y0);
    end

    always_ff @(posedge clk_rgb or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ce) begin
            if (swap) begin
                state_d = StClear;
            end else begin
                case (state_q)
                    StClear: begin
                        if (wr_addr_q == LastAddr) state_d = StWaitCmd;
                    end
                    StWaitCmd: begin
                        if (accept) begin
                            if (!cmd_empty)    state_d = StDraw;
                            else if (cmd_last) state_d = StDone;
                        end
                    end
                    StDraw: begin
                        if (last_col && last_row) state_d = last_q ? StDone : StWaitCmd;
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_comb begin
        wr_en_d      = wr_en_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cmd_ready_d  = cmd_ready_q;
        busy_d       = busy_q;
        frame_done_d = frame_done_q;
        overrun_d    = overrun_q;
        x_d          = x_q;
        y_d          = y_q;
        row_base_d   = row_base_q;
        x0_d         = x0_q;
        x1_d         = x1_q;
        y1_d         = y1_q;
        last_d       = last_q;
        if (ce) begin
            wr_en_d      = (state_d == StClear) || (state_d == StDraw);
            busy_d       = (state_d == StClear) || (state_d == StDraw);
            cmd_ready_d  = (state_d == StWaitCmd);
            frame_done_d = (state_d == StDone) && (state_q != StDone);
            overrun_d    = swap && (state_q inside {StClear, StWaitCmd, StDraw});
            if (swap) begin
                wr_addr_d = '0;
                wr_data_d = CLEAR_VALUE;
            end else begin
                case (state_q)
                    StClear: begin
                        if (wr_addr_q != LastAddr) wr_addr_d = wr_addr_q + AddrOne;
                    end
                    StWaitCmd: begin
                        if (accept && !cmd_empty) begin
                            x_d        = cmd_x0;
                            y_d        = cmd_y0;
                            x0_d       = cmd_x0;
                            x1_d       = x1_clip;
                            y1_d       = y1_clip;
                            last_d     = cmd_last;
                            row_base_d = row_base_new;
                            wr_addr_d  = row_base_new + ADDR_WIDTH'(cmd_x0);
                            wr_data_d  = cmd_color;
                        end
                    end
                    StDraw: begin
                        if (!last_col) begin
                            x_d       = x_q + XOne;
                            wr_addr_d = wr_addr_q + AddrOne;
                        end else if (!last_row) begin
                            x_d        = x0_q;
                            y_d        = y_q + YOne;
                            row_base_d = row_base_q + RowStep;
                            wr_addr_d  = row_base_q + RowStep + ADDR_WIDTH'(x0_q);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_rgb or posedge rst) begin
        if (rst) begin
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 1'b0;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            row_base_q   <= '0;
            x0_q         <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
            last_q       <= 1'b0;
        end else begin
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            x_q          <= x_d;
            y_q          <= y_d;
            row_base_q   <= row_base_d;
            x0_q         <= x0_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            last_q       <= last_d;
        end
    end

    // The strobe is gated so a disabled cycle never presents a write.
    assign wr_en      = wr_en_q & ce;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/rect_renderer.md
Name: rect_renderer

Overview:
- Drawing stage directly upstream of the 1-bit double-buffered frame buffer; drives its write port.
- On each frame-buffer swap pulse, clears the back buffer to a background value.
- Then rasterizes a stream of axis-aligned filled rectangles (bird, pipes, ground) received over a valid/ready command interface.
- Signals completion per frame and flags frames that did not finish before the next swap.

Parameters:
- HOR_ACTIVE_PIXELS, 640, visible width in pixels.
- VER_ACTIVE_PIXELS, 480, visible height in pixels.
- CLEAR_VALUE, 1'b0, pixel value written during clear.
- X_WIDTH, $clog2(HOR_ACTIVE_PIXELS), coordinate width.
- Y_WIDTH, $clog2(VER_ACTIVE_PIXELS), coordinate width.
- ADDR_WIDTH, $clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS), frame buffer address width.

Ports:
- clk_rgb  in  1  pixel clock; all logic on rising edge.
- rst  in  1  asynchronous reset, active-high.
- ce  in  1  clock enable; when low all state holds and wr_en=0.
- swap  in  1  one-cycle pulse; the back buffer changed and a new frame starts.
- cmd_valid  in  1  rectangle command valid.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready&&ce.
- cmd_x0  in  X_WIDTH+1  left edge, inclusive.
- cmd_y0  in  Y_WIDTH+1  top edge, inclusive.
- cmd_x1  in  X_WIDTH+1  right edge, exclusive.
- cmd_y1  in  Y_WIDTH+1  bottom edge, exclusive.
- cmd_color  in  1  pixel value for the rectangle.
- cmd_last  in  1  final rectangle of the frame.
- wr_en  out  1  frame buffer write strobe.
- wr_addr  out  ADDR_WIDTH  y*HOR_ACTIVE_PIXELS+x.
- wr_data  out  1  pixel value.
- busy  out  1  high in CLEAR or DRAW.
- frame_done  out  1  one-cycle pulse when the frame completes.
- overrun  out  1  one-cycle pulse when swap arrives before the frame completes.

Behaviour:
- Reset values: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, cmd_ready=0, busy=0, frame_done=0, overrun=0. All outputs are registered.
- FSM states: IDLE, CLEAR, WAIT_CMD, DRAW, DONE.
- swap in IDLE or DONE: go to CLEAR.
- swap in CLEAR, WAIT_CMD or DRAW: overrun pulses, current work is aborted, and the FSM restarts CLEAR at address 0. swap has priority over every other event in the same cycle.
- CLEAR:
  - One write per enabled cycle, address 0 up to H*V-1, data CLEAR_VALUE.
  - The first write appears the cycle after swap.
  - After the last address, go to WAIT_CMD; cmd_ready rises the following cycle.
- WAIT_CMD:
  - cmd_ready=1, no writes.
  - On accept, latch the command and clip: x1'=min(x1,H), y1'=min(y1,V).
  - If x0>=x1' or y0>=y1', the rectangle is empty: no writes; go to DONE if cmd_last, else stay in WAIT_CMD.
  - Otherwise go to DRAW; cmd_ready drops in the accept cycle+1.
- DRAW:
  - First write is in the cycle after accept, at (x0,y0).
  - Raster order: x increments, then wraps to x0 with y+1. One pixel per enabled cycle; data = cmd_color.
  - Address is kept as a row-base register plus x offset, advancing the row base by HOR_ACTIVE_PIXELS per row. No multiplier.
  - After pixel (x1'-1, y1'-1): go to DONE if cmd_last, else WAIT_CMD.
- DONE: frame_done pulses on entry for one cycle; the FSM waits for swap.
- Commands are overlapping-writes, last-wins; there is no arbitration with CLEAR (commands are not accepted during CLEAR).
- ce low: the FSM, counters and pulses freeze; wr_en=0. A swap arriving while ce=0 is ignored.
- rst mid-operation: immediate return to reset values; no further writes.

Test Plan:
- Reset, then hold 10 cycles -> all outputs 0, state IDLE, cmd_ready=0.
- swap pulse with ce=1 -> exactly 307200 writes at addresses 0..307199, data 0, contiguous; busy high throughout; then cmd_ready=1.
- Command (10,20)-(13,22), color 1, cmd_last=0 -> 6 writes at 12810, 12811, 12812, 13450, 13451, 13452, data 1; cmd_ready returns the next cycle.
- Clipped command (638,478)-(700,500) with cmd_last=1 -> 4 writes at 306558, 306559, 307198, 307199, then a one-cycle frame_done pulse.
- Empty command (50,50)-(50,60) -> zero writes; cmd_ready high again next cycle. swap mid-DRAW -> overrun pulse, next write at address 0 with CLEAR_VALUE.
- ce toggled 0/1 every other cycle during CLEAR -> addresses still contiguous with no gaps or duplicates; wr_en=0 whenever ce=0.
